if_id_queue: RTL and testbench

//  Instruction buffer directly downstream of the IF stage, upstream of ID.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/if_id_queue_if.sv | 42 ++++
 rtl/if_id_queue_mem.sv | 38 +++
 rtl/if_id_queue.sv | 103 ++++++++++
 tb/tb_if_id_queue.sv | 139 +++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
//  Constants shared by the IF, ID and EXE stages and by the IF/ID queue.
//  No ports; imported where needed.
// ---------------------------------------------------------------------------
package mips_pkg;

  // Width of instruction words and PC values throughout the pipeline.
  localparam int DATA_W = 32;

  // Instruction presented to ID when no real instruction is available.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Occupancy counter width for a queue of `depth` entries: needs to hold
  // 0..depth inclusive, hence one bit more than the address width.
  function automatic int occ_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : mips_pkg

// File: rtl/if_id_queue_if.sv
// ---------------------------------------------------------------------------
// if_id_queue_if
//  Handshake bundle between IF (producer), the IF/ID queue, and ID (consumer).
//  Signals:
//    flush                  branch-taken discard request
//    in_valid/in_ready      IF -> queue handshake (freeze = ~in_ready)
//    in_pc_inc/in_instr     entry offered by IF
//    out_valid/out_ready    queue -> ID handshake
//    out_pc_inc/out_instr   head entry (zero / NOP when empty)
//    count                  occupancy 0..DEPTH
//  Modports:
//    master : the pipeline side (IF + ID), drives requests and consumes status
//    slave  : the queue itself
// ---------------------------------------------------------------------------
interface if_id_queue_if #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = mips_pkg::occ_cnt_w(DEPTH);

  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_pc_inc;
  logic [DATA_W-1:0] in_instr;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_pc_inc;
  logic [DATA_W-1:0] out_instr;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, in_valid, in_pc_inc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc_inc, out_instr, count
  );

  modport slave (
    input  flush, in_valid, in_pc_inc, in_instr, out_ready,
    output in_ready, out_valid, out_pc_inc, out_instr, count
  );

endinterface : if_id_queue_if

// File: rtl/if_id_queue_mem.sv
// ---------------------------------------------------------------------------
// if_id_queue_mem
//  DEPTH x WIDTH storage for the IF/ID queue: one synchronous write port,
//  one asynchronous read port, contents not reset.
//  Ports:
//    clk      rising-edge clock
//    we_i     write enable
//    waddr_i  write address
//    wdata_i  write data
//    raddr_i  read address
//    rdata_o  read data (combinational from raddr_i)
// ---------------------------------------------------------------------------
module if_id_queue_mem #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Head must be visible in the same cycle the pointer moves, so the read
  // is asynchronous (distributed RAM / flops rather than block RAM).
  assign rdata_o = mem_q[raddr_i];

endmodule : if_id_queue_mem

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//  Instruction buffer between IF and ID. Captures {PC_inc, instr} whenever IF
//  offers one and there is room, and presents entries to ID in order. Lets IF
//  run ahead of a stalled ID until full; a taken branch (flush) drops every
//  buffered wrong-path entry.
//  Ports:
//    clk  rising-edge clock
//    rst  asynchronous active-high reset
//    q    if_id_queue_if.slave handshake bundle (see interface header)
// ---------------------------------------------------------------------------
module if_id_queue
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  q
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = occ_cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q,  count_d;

  logic                in_ready;
  logic                out_valid;
  logic                push;
  logic                pop;
  logic                mem_we;
  logic [2*DATA_W-1:0] head_entry;

  // Status depends on registered occupancy only; out_ready never reaches
  // in_ready, so a full queue refuses a push even while it is being popped.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);

  assign push = q.in_valid  & in_ready;
  assign pop  = out_valid   & q.out_ready;

  // A flush cycle discards the offered entry: no write, no pointer advance.
  assign mem_we = push & ~q.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;   // wraps naturally at DEPTH
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (2*DATA_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i ({q.in_pc_inc, q.in_instr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_entry)
  );

  // Storage is not reset, so the head is gated to zero / NOP whenever empty.
  assign q.in_ready   = in_ready;
  assign q.out_valid  = out_valid;
  assign q.out_pc_inc = out_valid ? head_entry[2*DATA_W-1:DATA_W] : '0;
  assign q.out_instr  = out_valid ? head_entry[DATA_W-1:0] : DATA_W'(NOP_INSTR);
  assign q.count      = count_q;

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
  import mips_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_id_queue_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus();

  if_id_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an ordered list of {pc_inc, instr} entries.
  logic [2*DW-1:0] model_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    logic [2*DW-1:0] head;
    int sz;
    sz   = model_q.size();
    head = (sz != 0) ? model_q[0] : '0;
    check_eq({ctx, ".out_valid"},  64'(bus.out_valid),  64'(sz != 0));
    check_eq({ctx, ".in_ready"},   64'(bus.in_ready),   64'(sz != DEPTH));
    check_eq({ctx, ".count"},      64'(bus.count),      64'(sz));
    check_eq({ctx, ".out_instr"},  64'(bus.out_instr),  (sz != 0) ? 64'(head[DW-1:0]) : 64'(NOP_INSTR));
    check_eq({ctx, ".out_pc_inc"}, 64'(bus.out_pc_inc), (sz != 0) ? 64'(head[2*DW-1:DW]) : 64'd0);
  endtask

  // One clock cycle: drive inputs after the falling edge, check the state
  // left by the previous rising edge, then advance the model at the edge.
  task automatic step(input string ctx, input logic fl, input logic iv,
                      input logic [DW-1:0] pc, input logic [DW-1:0] ins,
                      input logic ordy);
    int  sz;
    logic do_push, do_pop;
    @(negedge clk);
    bus.flush     = fl;
    bus.in_valid  = iv;
    bus.in_pc_inc = pc;
    bus.in_instr  = ins;
    bus.out_ready = ordy;
    #1;
    check_outputs(ctx);
    @(posedge clk);
    sz      = model_q.size();
    do_push = iv && (sz != DEPTH);
    do_pop  = ordy && (sz != 0);
    if (fl) begin
      model_q.delete();
      $display("t=%0t %s flush", $time, ctx);
    end else begin
      if (do_pop) begin
        $display("t=%0t %s pop  instr=%h pc=%h", $time, ctx, model_q[0][DW-1:0], model_q[0][2*DW-1:DW]);
        void'(model_q.pop_front());
      end
      if (do_push) begin
        model_q.push_back({pc, ins});
        $display("t=%0t %s push instr=%h pc=%h", $time, ctx, ins, pc);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 0; bus.in_valid = 0; bus.in_pc_inc = '0; bus.in_instr = '0; bus.out_ready = 0;
    #2;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Streaming: every entry appears one cycle after it is pushed.
    for (int i = 0; i < 4; i++)
      step("stream", 0, 1, 32'h100 + 32'(4*i), 32'hA + 32'(i), 1);
    step("stream_drain", 0, 0, '0, '0, 1);

    // Fill with ID stalled: only the first four are kept.
    for (int i = 0; i < 6; i++)
      step("fill", 0, 1, 32'h200 + 32'(4*i), 32'hA + 32'(i), 0);
    step("fill_pop", 0, 0, '0, '0, 1);

    // Back to full, then push+pop while full: the push must be refused.
    step("refill", 0, 1, 32'h300, 32'h30, 0);
    step("full_pp", 0, 1, 32'h304, 32'h31, 1);

    // Flush with both handshakes active.
    step("flush", 1, 1, 32'h400, 32'h99, 1);
    step("post_flush", 0, 1, 32'h500, 32'h40, 0);
    step("after_40", 0, 0, '0, '0, 0);

    // Asynchronous reset with three entries buffered.
    step("pre_rst", 0, 1, 32'h504, 32'h41, 0);
    step("pre_rst", 0, 1, 32'h508, 32'h42, 0);
    step("pre_rst", 0, 0, '0, '0, 0);
    @(negedge clk);
    bus.in_valid = 0; bus.out_ready = 0; bus.flush = 0;
    #2 rst = 1'b1;
    #1;
    model_q.delete();
    check_outputs("async_rst");
    #1 rst = 1'b0;

    // Wrap-around with alternating out_ready.
    for (int i = 0; i < 10; i++)
      step("wrap", 0, 1, 32'h600 + 32'(4*i), 32'h60 + 32'(i), logic'(i % 2));
    for (int i = 0; i < 6; i++)
      step("wrap_drain", 0, 0, '0, '0, 1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           $urandom, $urandom, ($urandom_range(0, 2) != 0));
    step("final", 0, 0, '0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_if_id_queue
